// File: rtl/vx_mem_perf_monitor_pkg.sv
// Shared definitions for the memory-traffic perf monitor: count modes and
// the counter snapshot record used by perf CSR readers.
package vx_mem_perf_monitor_pkg;

  localparam int COUNT_LANES = 0;
  localparam int COUNT_REQS  = 1;

  localparam int PERF_CTR_MAX_BITS = 64;

  typedef struct packed {
    logic [PERF_CTR_MAX_BITS-1:0] reads;
    logic [PERF_CTR_MAX_BITS-1:0] writes;
    logic [PERF_CTR_MAX_BITS-1:0] rsps;
    logic [PERF_CTR_MAX_BITS-1:0] latency_sum;
  } perf_mem_ctrs_t;

endpackage

// File: rtl/vx_mem_perf_monitor_sat_accum.sv
// Saturating accumulator with synchronous clear (dominant) and hold.
module vx_sat_accum #(
  parameter int W     = 44,
  parameter int INC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     value
);

  // One extra bit over the wider operand so the carry out is never lost.
  localparam int SW = ((W > INC_W) ? W : INC_W) + 1;

  logic [SW-1:0] sum;
  logic [W-1:0]  next_value;

  always_comb begin
    sum = SW'(value) + SW'(inc);
    if (sum > SW'({W{1'b1}})) next_value = '1;
    else                      next_value = sum[W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     value <= '0;
    else if (clear) value <= '0;
    else if (!hold) value <= next_value;
  end

endmodule

// File: rtl/vx_mem_perf_monitor.sv
// Memory-traffic perf monitor: counts read/write/response lanes over N channel
// pairs, tracks outstanding reads, latency sum, peak occupancy and underflow.
module vx_mem_perf_monitor
  import vx_mem_perf_monitor_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_LANES    = 4,
  parameter int COUNT_MODE   = 0,
  parameter int CTR_BITS     = 44,
  parameter int PEND_BITS    = 16,
  parameter int REQ_BUF      = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           req_valid,
  input  logic [NUM_CHANNELS-1:0]           req_ready,
  input  logic [NUM_CHANNELS-1:0]           req_rw,
  input  logic [NUM_CHANNELS*NUM_LANES-1:0] req_mask,
  input  logic [NUM_CHANNELS-1:0]           rsp_valid,
  input  logic [NUM_CHANNELS-1:0]           rsp_ready,
  input  logic [NUM_CHANNELS*NUM_LANES-1:0] rsp_mask,
  input  logic                              clear,
  input  logic                              freeze,
  output logic [CTR_BITS-1:0]               reads,
  output logic [CTR_BITS-1:0]               writes,
  output logic [CTR_BITS-1:0]               rsps,
  output logic [CTR_BITS-1:0]               latency_sum,
  output logic [PEND_BITS-1:0]              pending,
  output logic [PEND_BITS-1:0]              peak_pending,
  output logic                              err_underflow
);

  localparam int NL = NUM_CHANNELS * NUM_LANES;
  localparam int CW = $clog2(NL + 1);
  localparam int SW = PEND_BITS + CW + 1;

  // Handshake: a request/response is taken when valid and ready are both high.
  logic [NL-1:0] rd_fire, wr_fire, rsp_fire, rd_cnt_vec, wr_cnt_vec;
  logic          req_lane, rsp_lane;

  always_comb begin
    rd_fire  = '0;
    wr_fire  = '0;
    rsp_fire = '0;
    req_lane = 1'b0;
    rsp_lane = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        // Request mode folds each fired transaction onto lane 0 so it counts once.
        if (COUNT_MODE == COUNT_LANES) begin
          req_lane = req_mask[c*NUM_LANES + l];
          rsp_lane = rsp_mask[c*NUM_LANES + l];
        end else begin
          req_lane = (l == 0) && (|req_mask[c*NUM_LANES +: NUM_LANES]);
          rsp_lane = (l == 0) && (|rsp_mask[c*NUM_LANES +: NUM_LANES]);
        end
        rd_fire[c*NUM_LANES + l]  = req_valid[c] & req_ready[c] & ~req_rw[c] & req_lane;
        wr_fire[c*NUM_LANES + l]  = req_valid[c] & req_ready[c] &  req_rw[c] & req_lane;
        rsp_fire[c*NUM_LANES + l] = rsp_valid[c] & rsp_ready[c] & rsp_lane;
      end
    end
  end

  if (REQ_BUF != 0) begin : g_req_buf
    logic [NL-1:0] rd_q, wr_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        rd_q <= rd_fire;
        wr_q <= wr_fire;
      end
    end
    assign rd_cnt_vec = rd_q;
    assign wr_cnt_vec = wr_q;
  end else begin : g_req_direct
    assign rd_cnt_vec = rd_fire;
    assign wr_cnt_vec = wr_fire;
  end

  function automatic logic [CW-1:0] popcnt(input logic [NL-1:0] v);
    popcnt = '0;
    for (int i = 0; i < NL; i++) popcnt = popcnt + CW'(v[i]);
  endfunction

  logic [CW-1:0]        nrd, nwr, nrsp;
  logic [SW-1:0]        pend_calc;
  logic [PEND_BITS-1:0] pend_next;
  logic                 underflow;

  // Magnitudes fit in SW-1 bits, so the top bit of the two's-complement result is the sign.
  always_comb begin
    nrd       = popcnt(rd_cnt_vec);
    nwr       = popcnt(wr_cnt_vec);
    nrsp      = popcnt(rsp_fire);
    pend_calc = SW'(pending) + SW'(nrd) - SW'(nrsp);
    underflow = 1'b0;
    if (pend_calc[SW-1]) begin
      pend_next = '0;
      underflow = 1'b1;
    end else if (|pend_calc[SW-2:PEND_BITS]) begin
      pend_next = '1;
    end else begin
      pend_next = pend_calc[PEND_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending       <= '0;
      peak_pending  <= '0;
      err_underflow <= 1'b0;
    end else begin
      pending <= pend_next;
      if (clear) begin
        peak_pending  <= pend_next;
        err_underflow <= 1'b0;
      end else begin
        if (pend_next > peak_pending) peak_pending <= pend_next;
        err_underflow <= err_underflow | underflow;
      end
    end
  end

  vx_sat_accum #(.W(CTR_BITS), .INC_W(CW)) u_reads (
    .clk(clk), .reset(reset), .clear(clear), .hold(freeze), .inc(nrd), .value(reads)
  );

  vx_sat_accum #(.W(CTR_BITS), .INC_W(CW)) u_writes (
    .clk(clk), .reset(reset), .clear(clear), .hold(freeze), .inc(nwr), .value(writes)
  );

  vx_sat_accum #(.W(CTR_BITS), .INC_W(CW)) u_rsps (
    .clk(clk), .reset(reset), .clear(clear), .hold(freeze), .inc(nrsp), .value(rsps)
  );

  vx_sat_accum #(.W(CTR_BITS), .INC_W(PEND_BITS)) u_latency (
    .clk(clk), .reset(reset), .clear(clear), .hold(freeze), .inc(pending), .value(latency_sum)
  );

endmodule
